wb_stream_bridge: RTL and testbench

- Parametrised Wishbone-slave-to-stream bridge between the Caravel management Wishbone bus and the vector coprocessor's load, instruction and store val/rdy streams.
- Successor to the fixed 64/32/32 unbuffered converter. Adds:
  - configurable load width;
  - per-channel FIFOs;
  - memory-mapped status registers with sticky error flags;
  - optional blocking mode that stalls the Wishbone ack on full/empty.
- Single clock domain; the Wishbone clock is tied to the coprocessor clock at the wrapper.

---
 rtl/wb_stream_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_wb_stream_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_bridge.sv
// Wishbone slave to val/rdy stream bridge: instruction/load push streams,
// store pop stream, status register with sticky overflow/underflow flags.

module wb_stream_bridge_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [7:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Full/empty come from the registered count; push on full is refused
  // even when a pop happens in the same cycle.
  always_comb begin
    o_full  = (r_count == CNT_MAX);
    o_empty = (r_count == '0);
    o_data  = r_mem[r_rptr];
    o_count = 8'(r_count);
    w_push  = i_push & ~o_full;
    w_pop   = i_pop & ~o_empty;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

module wb_stream_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned LOAD_W      = 64,
  parameter int unsigned INSTR_DEPTH = 4,
  parameter int unsigned LOAD_DEPTH  = 4,
  parameter int unsigned STORE_DEPTH = 4,
  parameter bit          BLOCKING    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [31:0]       instruction_recv_msg,
  output logic              instruction_recv_val,
  input  logic              instruction_recv_rdy,
  output logic [LOAD_W-1:0] load_recv_msg,
  output logic              load_recv_val,
  input  logic              load_recv_rdy,
  input  logic [31:0]       store_send_msg,
  input  logic              store_send_val,
  output logic              store_send_rdy
);
  localparam int unsigned LOAD_WORDS = LOAD_W / 32;
  localparam int unsigned IDX_W      = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LOAD_WORDS - 1);
  localparam logic [5:0]       N_WORDS  = 6'(LOAD_WORDS);

  logic [31:0]       r_stage [LOAD_WORDS];
  logic              r_ovf;
  logic              r_unf;

  logic [7:0]        w_off;
  logic [5:0]        w_load_word;
  logic [IDX_W-1:0]  w_load_idx;
  logic              w_match, w_req, w_stall, w_service;
  logic              w_is_instr, w_is_store, w_is_status, w_is_load, w_load_last;
  logic              w_instr_push, w_load_push, w_store_pop, w_status_wr, w_stage_wr;
  logic              w_ovf_set, w_unf_set;
  logic [31:0]       w_merged;
  logic [LOAD_W-1:0] w_load_msg;
  logic [31:0]       w_status;
  logic [31:0]       w_rdata;

  logic              w_instr_full, w_instr_empty;
  logic              w_load_full, w_load_empty;
  logic              w_store_full, w_store_empty;
  logic [7:0]        w_instr_cnt, w_load_cnt, w_store_cnt;
  logic [31:0]       w_store_head;

  // Address decode and request qualification; a stalled request simply
  // stays un-serviced while the master keeps stb/cyc asserted.
  always_comb begin
    w_off       = wbs_adr_i[7:0];
    w_match     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    w_req       = wbs_stb_i & wbs_cyc_i & w_match & ~wbs_ack_o;
    w_load_word = w_off[7:2] - 6'h04;
    w_load_idx  = w_load_word[IDX_W-1:0];
    w_is_instr  = (w_off == 8'h00);
    w_is_store  = (w_off == 8'h04);
    w_is_status = (w_off == 8'h08);
    w_is_load   = (w_off[7:4] != 4'h0) && (w_off[1:0] == 2'b00) && (w_load_word < N_WORDS);
    w_load_last = w_is_load && (w_load_idx == LAST_IDX);
    w_stall     = BLOCKING && (( wbs_we_i && w_is_instr  && w_instr_full) ||
                               ( wbs_we_i && w_load_last && w_load_full)  ||
                               (!wbs_we_i && w_is_store  && w_store_empty));
    w_service    = w_req & ~w_stall;
    w_instr_push = w_service &  wbs_we_i & w_is_instr;
    w_load_push  = w_service &  wbs_we_i & w_load_last;
    w_stage_wr   = w_service &  wbs_we_i & w_is_load;
    w_status_wr  = w_service &  wbs_we_i & w_is_status;
    w_store_pop  = w_service & ~wbs_we_i & w_is_store;
    w_ovf_set    = (w_instr_push & w_instr_full) | (w_load_push & w_load_full);
    w_unf_set    = w_store_pop & w_store_empty;
  end

  // Byte-masked staging merge; the last word's new value goes straight into
  // the pushed message since the staging register updates on the same edge.
  always_comb begin
    w_merged   = '0;
    w_load_msg = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      w_merged[b*8 +: 8] = wbs_sel_i[b] ? wbs_dat_i[b*8 +: 8] : r_stage[w_load_idx][b*8 +: 8];
    end
    for (int unsigned i = 0; i < LOAD_WORDS; i++) begin
      w_load_msg[i*32 +: 32] = r_stage[i];
    end
    w_load_msg[LOAD_W-32 +: 32] = w_merged;
  end

  // Status word and read-data mux.
  always_comb begin
    w_status = {3'b000, r_unf, r_ovf, w_store_empty, w_load_full, w_instr_full,
                w_store_cnt, w_load_cnt, w_instr_cnt};
    w_rdata  = '0;
    if (!wbs_we_i) begin
      if (w_is_store && !w_store_empty) w_rdata = w_store_head;
      else if (w_is_status)             w_rdata = w_status;
    end
  end

  // Registered single-cycle ack with data; data bus is zero when not acking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= w_service;
      wbs_dat_o <= w_service ? w_rdata : '0;
    end
  end

  // Load staging words and sticky error flags (set wins over W1C clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LOAD_WORDS; i++) r_stage[i] <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_stage_wr) r_stage[w_load_idx] <= w_merged;
      r_ovf <= w_ovf_set | (r_ovf & ~(w_status_wr & wbs_dat_i[27]));
      r_unf <= w_unf_set | (r_unf & ~(w_status_wr & wbs_dat_i[28]));
    end
  end

  // Stream-side handshake outputs.
  always_comb begin
    instruction_recv_val = ~w_instr_empty;
    load_recv_val        = ~w_load_empty;
    store_send_rdy       = ~w_store_full;
  end

  wb_stream_bridge_fifo #(.W(32), .DEPTH(INSTR_DEPTH)) u_instr_fifo (
    .clk(clk), .reset(reset), .i_push(w_instr_push), .i_data(wbs_dat_i),
    .i_pop(instruction_recv_rdy), .o_data(instruction_recv_msg), .o_count(w_instr_cnt),
    .o_full(w_instr_full), .o_empty(w_instr_empty)
  );

  wb_stream_bridge_fifo #(.W(LOAD_W), .DEPTH(LOAD_DEPTH)) u_load_fifo (
    .clk(clk), .reset(reset), .i_push(w_load_push), .i_data(w_load_msg),
    .i_pop(load_recv_rdy), .o_data(load_recv_msg), .o_count(w_load_cnt),
    .o_full(w_load_full), .o_empty(w_load_empty)
  );

  wb_stream_bridge_fifo #(.W(32), .DEPTH(STORE_DEPTH)) u_store_fifo (
    .clk(clk), .reset(reset), .i_push(store_send_val), .i_data(store_send_msg),
    .i_pop(w_store_pop), .o_data(w_store_head), .o_count(w_store_cnt),
    .o_full(w_store_full), .o_empty(w_store_empty)
  );
endmodule

// File: tb/tb_wb_stream_bridge.sv
// Directed bench: dut0 is the dropping variant, dut1 the blocking variant.

module tb_wb_stream_bridge;
  localparam logic [31:0] A_INSTR  = 32'h3000_0000;
  localparam logic [31:0] A_STORE  = 32'h3000_0004;
  localparam logic [31:0] A_STATUS = 32'h3000_0008;
  localparam logic [31:0] A_LOAD0  = 32'h3000_0010;
  localparam logic [31:0] A_LOAD1  = 32'h3000_0014;

  logic        clk, reset;
  logic        stb0, stb1, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat, wb_adr;
  logic        irdy, lrdy;
  logic [31:0] smsg;
  logic        sval0, sval1;

  logic        ack0, ival0, lval0, srdy0;
  logic [31:0] dat0, imsg0;
  logic [63:0] lmsg0;
  logic        ack1, ival1, lval1, srdy1;
  logic [31:0] dat1, imsg1;
  logic [63:0] lmsg1;

  int          n_asrt = 0;
  int          n_fail = 0;
  logic [31:0] rd;
  int          lat;
  int          acks;
  logic        seen;

  wb_stream_bridge #(.LOAD_W(64), .INSTR_DEPTH(4), .BLOCKING(1'b0)) dut0 (
    .clk(clk), .reset(reset), .wbs_stb_i(stb0), .wbs_cyc_i(stb0), .wbs_we_i(wb_we),
    .wbs_sel_i(wb_sel), .wbs_dat_i(wb_dat), .wbs_adr_i(wb_adr), .wbs_ack_o(ack0),
    .wbs_dat_o(dat0), .instruction_recv_msg(imsg0), .instruction_recv_val(ival0),
    .instruction_recv_rdy(irdy), .load_recv_msg(lmsg0), .load_recv_val(lval0),
    .load_recv_rdy(lrdy), .store_send_msg(smsg), .store_send_val(sval0),
    .store_send_rdy(srdy0)
  );

  wb_stream_bridge #(.LOAD_W(64), .INSTR_DEPTH(4), .BLOCKING(1'b1)) dut1 (
    .clk(clk), .reset(reset), .wbs_stb_i(stb1), .wbs_cyc_i(stb1), .wbs_we_i(wb_we),
    .wbs_sel_i(wb_sel), .wbs_dat_i(wb_dat), .wbs_adr_i(wb_adr), .wbs_ack_o(ack1),
    .wbs_dat_o(dat1), .instruction_recv_msg(imsg1), .instruction_recv_val(ival1),
    .instruction_recv_rdy(irdy), .load_recv_msg(lmsg1), .load_recv_val(lval1),
    .load_recv_rdy(lrdy), .store_send_msg(smsg), .store_send_val(sval1),
    .store_send_rdy(srdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One Wishbone access on dut d; lat = edges until ack, -1 if none in max_wait.
  task automatic wb_cycle(input bit d, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input logic pop_i,
                          input int max_wait, output logic [31:0] rdata, output int latency);
    @(posedge clk); #1;
    wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel; irdy = pop_i;
    stb0 = ~d; stb1 = d;
    latency = -1; rdata = '0;
    for (int c = 1; c <= max_wait; c++) begin
      @(posedge clk); #1;
      irdy = 1'b0;
      if (d ? ack1 : ack0) begin
        latency = c;
        rdata = d ? dat1 : dat0;
        break;
      end
    end
    stb0 = 1'b0; stb1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stb0 = 1'b0; stb1 = 1'b0; wb_we = 1'b0; wb_sel = 4'h0;
    wb_dat = '0; wb_adr = '0; irdy = 1'b0; lrdy = 1'b0; smsg = '0; sval0 = 1'b0; sval1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_ack", 64'(ack0), 64'h0);
    check("rst_dat", 64'(dat0), 64'h0);
    check("rst_ival", 64'(ival0), 64'h0);
    check("rst_lval", 64'(lval0), 64'h0);
    check("rst_srdy", 64'(srdy0), 64'h1);
    wb_cycle(0, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("rst_status", 64'(rd), 64'h0400_0000);
    check("status_lat", 64'(lat), 64'(1));

    // Instruction push
    wb_cycle(0, 1'b1, A_INSTR, 32'hDEAD_BEEF, 4'hF, 1'b0, 4, rd, lat);
    check("instr_lat", 64'(lat), 64'(1));
    check("instr_val", 64'(ival0), 64'h1);
    check("instr_msg", 64'(imsg0), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    check("ack_one_cycle", 64'(ack0), 64'h0);
    wb_cycle(0, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("status_i1", 64'(rd), 64'h0400_0001);
    @(posedge clk); #1;
    check("dat_idle_zero", 64'(dat0), 64'h0);

    // Load staging with byte mask, then full message
    wb_cycle(0, 1'b1, A_LOAD0, 32'hAABB_CCFF, 4'b0001, 1'b0, 4, rd, lat);
    wb_cycle(0, 1'b1, A_LOAD1, 32'h3333_4444, 4'hF, 1'b0, 4, rd, lat);
    check("load_val", 64'(lval0), 64'h1);
    check("load_msg_mask", lmsg0, 64'h3333_4444_0000_00FF);
    @(posedge clk); #1 lrdy = 1'b1;
    @(posedge clk); #1 lrdy = 1'b0;
    check("load_popped", 64'(lval0), 64'h0);
    wb_cycle(0, 1'b1, A_LOAD0, 32'h1111_2222, 4'hF, 1'b0, 4, rd, lat);
    wb_cycle(0, 1'b1, A_LOAD1, 32'h3333_4444, 4'hF, 1'b0, 4, rd, lat);
    check("load_msg", lmsg0, 64'h3333_4444_1111_2222);

    // Instruction overflow: 1 entry present, 4 more writes, last one dropped
    acks = 0;
    for (int i = 1; i <= 4; i++) begin
      wb_cycle(0, 1'b1, A_INSTR, 32'(i), 4'hF, 1'b0, 4, rd, lat);
      if (lat == 1) acks++;
    end
    check("ovf_acks", 64'(acks), 64'(4));
    wb_cycle(0, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("status_ovf", 64'(rd), 64'h0D00_0104);
    wb_cycle(0, 1'b1, A_STATUS, 32'h0800_0000, 4'hF, 1'b0, 4, rd, lat);
    wb_cycle(0, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("status_w1c", 64'(rd), 64'h0500_0104);

    // Full FIFO, pop and push on the same edge: push rejected
    wb_cycle(0, 1'b1, A_INSTR, 32'h0000_0099, 4'hF, 1'b1, 4, rd, lat);
    check("full_pop_head", 64'(imsg0), 64'h1);
    wb_cycle(0, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("status_full_pop", 64'(rd), 64'h0C00_0103);

    // Store path and underflow
    @(posedge clk); #1 smsg = 32'hA5; sval0 = 1'b1;
    @(posedge clk); #1 smsg = 32'h5A;
    @(posedge clk); #1 sval0 = 1'b0;
    wb_cycle(0, 1'b0, A_STORE, '0, 4'hF, 1'b0, 4, rd, lat);
    check("store_rd0", 64'(rd), 64'hA5);
    wb_cycle(0, 1'b0, A_STORE, '0, 4'hF, 1'b0, 4, rd, lat);
    check("store_rd1", 64'(rd), 64'h5A);
    wb_cycle(0, 1'b0, A_STORE, '0, 4'hF, 1'b0, 4, rd, lat);
    check("store_empty_rd", 64'(rd), 64'h0);
    check("store_empty_lat", 64'(lat), 64'(1));
    wb_cycle(0, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("status_unf", 64'(rd), 64'h1C00_0103);

    // Store FIFO fills; fifth beat refused
    sval0 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      smsg = 32'(i);
      @(posedge clk); #1;
    end
    sval0 = 1'b0;
    check("store_full_rdy", 64'(srdy0), 64'h0);
    wb_cycle(0, 1'b0, A_STORE, '0, 4'hF, 1'b0, 4, rd, lat);
    check("store_full_head", 64'(rd), 64'h1);
    check("store_rdy_back", 64'(srdy0), 64'h1);

    // Decode
    wb_cycle(0, 1'b1, 32'h4000_0000, 32'h1234, 4'hF, 1'b0, 4, rd, lat);
    check("nomatch_noack", 64'(lat), 64'(-1));
    wb_cycle(0, 1'b0, 32'h3000_000C, '0, 4'hF, 1'b0, 4, rd, lat);
    check("unmapped_rd", 64'(rd), 64'h0);
    check("unmapped_lat", 64'(lat), 64'(1));

    // Blocking store read waits for data
    @(posedge clk); #1;
    wb_we = 1'b0; wb_adr = A_STORE; stb1 = 1'b1; seen = 1'b0;
    repeat (4) begin @(posedge clk); #1 seen |= ack1; end
    check("blk_stall", 64'(seen), 64'h0);
    smsg = 32'h77; sval1 = 1'b1;
    @(posedge clk); #1 sval1 = 1'b0;
    check("blk_ack_after_push", 64'(ack1), 64'h0);
    @(posedge clk); #1;
    check("blk_ack", 64'(ack1), 64'h1);
    check("blk_data", 64'(dat1), 64'h77);
    stb1 = 1'b0;
    wb_cycle(1, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("blk_status", 64'(rd), 64'h0400_0000);

    // Reset during a stalled blocking read
    wb_cycle(1, 1'b1, A_INSTR, 32'hCAFE_F00D, 4'hF, 1'b0, 4, rd, lat);
    check("blk_ival", 64'(ival1), 64'h1);
    @(posedge clk); #1;
    wb_we = 1'b0; wb_adr = A_STORE; stb1 = 1'b1; seen = 1'b0;
    repeat (3) begin @(posedge clk); #1 seen |= ack1; end
    reset = 1'b1;
    @(posedge clk); #1 seen |= ack1; stb1 = 1'b0;
    @(posedge clk); #1 seen |= ack1; reset = 1'b0;
    repeat (3) begin @(posedge clk); #1 seen |= ack1; end
    check("rst_stall_noack", 64'(seen), 64'h0);
    check("rst2_ival1", 64'(ival1), 64'h0);
    check("rst2_ival0", 64'(ival0), 64'h0);
    check("rst2_lval0", 64'(lval0), 64'h0);
    check("rst2_srdy0", 64'(srdy0), 64'h1);
    wb_cycle(1, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("rst2_status1", 64'(rd), 64'h0400_0000);
    wb_cycle(0, 1'b0, A_STATUS, '0, 4'hF, 1'b0, 4, rd, lat);
    check("rst2_status0", 64'(rd), 64'h0400_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
